// File: rtl/mips_alu_muldiv.sv
// Execute-stage ALU with a registered valid/ready output beat and an
// iterative multiply/divide unit that owns the architectural HI/LO registers.
module mips_alu_muldiv #(
    parameter int WIDTH     = 32,
    parameter int SHAMT_W   = 5,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipeline_flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [4:0]       alu_op_i,
    input  logic [WIDTH-1:0] alu_input1_i,
    input  logic [WIDTH-1:0] alu_input2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] alu_result_o,
    output logic             overflow_o,
    output logic             zero_o,
    output logic             negative_o,
    output logic             busy_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state;
    logic [WIDTH-1:0]   hi, lo, mcand, acc_hi, acc_lo;
    logic [CNT_W-1:0]   cnt;
    logic               neg_lo, neg_hi, div_zero;

    logic               accept, is_muldiv, sgn_op;
    logic [WIDTH-1:0]   a, b, sum, diff, res, abs_a, abs_b;
    logic               ovf;

    assign a          = alu_input1_i;
    assign b          = alu_input2_i;
    assign in_ready_o = (state == IDLE) && (!out_valid_o || out_ready_i);
    assign busy_o     = (state != IDLE);
    assign accept     = in_valid_i && in_ready_o && !pipeline_flush_i;
    assign is_muldiv  = MULDIV_EN && (alu_op_i >= 5'd14) && (alu_op_i <= 5'd17);
    // MULT (14) and DIV (16) are the signed variants
    assign sgn_op     = !alu_op_i[0];
    assign abs_a      = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign abs_b      = (sgn_op && b[WIDTH-1]) ? -b : b;
    assign sum        = a + b;
    assign diff       = a - b;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (alu_op_i)
            5'd0:  begin
                res = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            5'd1:  res = sum;
            5'd2:  begin
                res = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            5'd3:  res = diff;
            5'd4:  res = a & b;
            5'd5:  res = a | b;
            5'd6:  res = a ^ b;
            5'd7:  res = ~(a | b);
            5'd8:  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            5'd9:  res = {{(WIDTH-1){1'b0}}, a < b};
            5'd10: res = a << b[SHAMT_W-1:0];
            5'd11: res = a >> b[SHAMT_W-1:0];
            5'd12: res = WIDTH'($signed(a) >>> b[SHAMT_W-1:0]);
            5'd13: res = b << (WIDTH / 2);
            5'd18: res = hi;
            5'd19: res = lo;
            5'd20, 5'd21: res = a;
            default: res = '0;
        endcase
    end

    // One iteration: shift-add for MUL, restoring subtract for DIV.
    // acc_hi holds partial product / remainder, acc_lo multiplier / quotient.
    logic [WIDTH:0]     mul_sum, div_shift, div_sub;
    logic               div_ok;
    logic [2*WIDTH-1:0] step, prod;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_sub   = div_shift - {1'b0, mcand};
        div_ok    = div_shift >= {1'b0, mcand};
        if (state == MUL)
            step = {mul_sum, acc_lo[WIDTH-1:1]};
        else
            step = {(div_ok ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                    acc_lo[WIDTH-2:0], div_ok};
        prod = neg_lo ? -step : step;
        if (state == MUL) begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end else begin
            fin_hi = neg_hi ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
            fin_lo = div_zero ? '1 : (neg_lo ? -step[WIDTH-1:0] : step[WIDTH-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            hi           <= '0;
            lo           <= '0;
            mcand        <= '0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            neg_lo       <= 1'b0;
            neg_hi       <= 1'b0;
            div_zero     <= 1'b0;
            out_valid_o  <= 1'b0;
            alu_result_o <= '0;
            overflow_o   <= 1'b0;
            zero_o       <= 1'b0;
            negative_o   <= 1'b0;
        end else if (pipeline_flush_i) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_o <= 1'b0;
        end else begin
            if (out_valid_o && out_ready_i)
                out_valid_o <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (is_muldiv) begin
                        state    <= (alu_op_i < 5'd16) ? MUL : DIV;
                        cnt      <= CNT_W'(WIDTH);
                        mcand    <= abs_b;
                        acc_hi   <= '0;
                        acc_lo   <= abs_a;
                        neg_lo   <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi   <= sgn_op && a[WIDTH-1];
                        div_zero <= (b == '0);
                    end else begin
                        out_valid_o  <= 1'b1;
                        alu_result_o <= res;
                        overflow_o   <= ovf;
                        zero_o       <= (res == '0);
                        negative_o   <= res[WIDTH-1];
                        if (alu_op_i == 5'd20) hi <= a;
                        if (alu_op_i == 5'd21) lo <= a;
                    end
                end
                default: begin
                    {acc_hi, acc_lo} <= step;
                    cnt              <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state        <= IDLE;
                        hi           <= fin_hi;
                        lo           <= fin_lo;
                        out_valid_o  <= 1'b1;
                        alu_result_o <= fin_lo;
                        overflow_o   <= 1'b0;
                        zero_o       <= (fin_lo == '0);
                        negative_o   <= fin_lo[WIDTH-1];
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_alu_muldiv.sv
// Directed bench: stimulus pushes expected beats into a queue, an
// independent monitor pops and compares every accepted output beat.
module tb_mips_alu_muldiv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_op = '0;
    logic [31:0] a = '0, b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        overflow, zero, negative, busy;

    typedef struct {logic [31:0] res; logic ovf;} exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_alu_muldiv #(.WIDTH(32), .SHAMT_W(5), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .pipeline_flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .alu_op_i(alu_op),
        .alu_input1_i(a), .alu_input2_i(b), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .alu_result_o(result), .overflow_o(overflow),
        .zero_o(zero), .negative_o(negative), .busy_o(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every beat taken by the consumer must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_beat", result, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("beat_result", result, e.res);
                check("beat_flags", {29'd0, overflow, zero, negative},
                      {29'd0, e.ovf, e.res == 32'd0, e.res[31]});
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic eo, input bit push);
        int n;
        exp_t e;
        @(negedge clk);
        alu_op = op; a = x; b = y; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("issue_timeout", 32'(n), 32'd0);
        e.res = er; e.ovf = eo;
        if (push) q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_busy_flags", {28'd0, busy, overflow, zero, negative}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        issue(5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1'b1);
        check("add_valid_next", {31'd0, out_valid}, 32'd1);
        issue(5'd1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
        issue(5'd2, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1);
        issue(5'd12, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b1);
        issue(5'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b1);
        issue(5'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1);
        issue(5'd13, 32'd0, 32'h1234, 32'h1234_0000, 1'b0, 1'b1);

        // MULT -2 x 3 and busy window length
        issue(5'd14, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 1'b0, 1'b1);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        check("mult_busy_cycles", 32'(n), 32'd32);
        issue(5'd18, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        issue(5'd19, 32'd0, 32'd0, 32'hFFFF_FFFA, 1'b0, 1'b1);

        issue(5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b1);
        issue(5'd18, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        issue(5'd17, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        issue(5'd18, 32'd0, 32'd0, 32'd7, 1'b0, 1'b1);
        issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
        issue(5'd18, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Backpressure: result held, input stalled, release accepts next op at once
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        issue(5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1);
        alu_op = 5'd5; a = 32'hF0; b = 32'h0F; in_valid = 1'b1;
        begin
            exp_t e;
            e.res = 32'hFF; e.ovf = 1'b0;
            q.push_back(e);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_result", result, 32'd5);
            check("bp_state", {28'd0, out_valid, overflow, zero, in_ready}, 32'b1000);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp_next_accepted", {out_valid, 31'd0} | result, 32'h8000_00FF);

        // Flush mid-MULTU: no beat, HI/LO keep the moved values
        issue(5'd20, 32'hA, 32'd0, 32'hA, 1'b0, 1'b1);
        issue(5'd21, 32'hB, 32'd0, 32'hB, 1'b0, 1'b1);
        issue(5'd15, 32'd5, 32'd6, 32'd0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        repeat (40) @(posedge clk);
        issue(5'd18, 32'd0, 32'd0, 32'hA, 1'b0, 1'b1);
        issue(5'd19, 32'd0, 32'd0, 32'hB, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_alu_muldiv.md
Name: mips_alu_muldiv

Overview:
- Parametrised, handshaked successor to the single-cycle execute ALU.
- Adds a registered output stage with valid/ready flow control.
- Adds an iterative multiply/divide unit with architectural HI/LO registers and the MFHI/MFLO/MTHI/MTLO moves.
- Sits in the execute stage between decode/operand-select and memory; honours pipeline flush.

Parameters:
- WIDTH, 32, operand/result width; even, >= 8.
- SHAMT_W, 5, shift-amount bits; must equal log2(WIDTH).
- MULDIV_EN, 1, when 0 ops 14-17 execute as single-cycle with result 0 and HI/LO untouched.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset asynchronous active-low
- pipeline_flush_i  in  1  abort in-flight work
- in_valid_i  in  1  operation offered
- in_ready_o  out  1  operation accepted when in_valid_i && in_ready_o at rising edge
- alu_op_i  in  5  decoded op code (see Behaviour)
- alu_input1_i  in  WIDTH  operand A (rs)
- alu_input2_i  in  WIDTH  operand B (rt/imm; low SHAMT_W bits = shift amount)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer takes result
- alu_result_o  out  WIDTH  result
- overflow_o  out  1  signed overflow (ADD/SUB only)
- zero_o  out  1  alu_result_o == 0
- negative_o  out  1  alu_result_o[WIDTH-1]
- busy_o  out  1  mul/div iterating

Behaviour:
- Reset (rst_n low, async): state IDLE; out_valid_o, alu_result_o, flags, busy_o, HI, LO and the iteration counter all cleared. in_ready_o = 1 after reset release.
- Op codes:
  - 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR.
  - 8 SLT (signed, result 1/0), 9 SLTU.
  - 10 SLL, 11 SRL, 12 SRA: shift A by B[SHAMT_W-1:0].
  - 13 LUI: B << WIDTH/2.
  - 14 MULT, 15 MULTU, 16 DIV, 17 DIVU.
  - 18 MFHI, 19 MFLO, 20 MTHI (HI<=A), 21 MTLO (LO<=A).
  - Codes 22-31: result 0, no side effects.
- Overflow: set only for ADD/SUB. ADD: sign(A)==sign(B) and sign(result) differs. SUB: sign(A)!=sign(B) and sign(result)!=sign(A). Result is still written; trapping belongs to the consumer.
- in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i); combinational.
- Single-cycle ops, accepted at edge N:
  - Output register loads at edge N; out_valid_o is high from cycle N+1.
  - MTHI/MTLO update HI/LO at edge N and produce an output beat with result = A.
- Output register holds result and flags stable while out_valid_o && !out_ready_i. Back-to-back issue is allowed when out_ready_i=1: one op per cycle.
- State machine: IDLE -> MUL (ops 14/15) or DIV (ops 16/17) on accept; busy_o=1 in MUL/DIV.
  - Iteration: operands are latched as magnitudes (signed ops record the result signs), counter = WIDTH, one shift-add (MUL) or restoring-subtract (DIV) step per cycle.
  - Final step (counter==1): applies sign correction, writes {HI,LO}, loads the output register with result = LO, sets out_valid_o, and returns to IDLE.
  - Latency: op accepted at edge N -> out_valid_o high from cycle N+WIDTH.
- MULT/MULTU: {HI,LO} = 2*WIDTH-bit product.
- DIV/DIVU: LO = quotient (truncated toward zero), HI = remainder (takes the sign of the dividend).
  - Divide by zero: LO = all-ones, HI = dividend; normal latency.
  - Signed MIN / -1: LO = MIN, HI = 0.
- MFHI/MFLO are issued only from IDLE, so they always see completed HI/LO; no forwarding hazard.
- pipeline_flush_i (synchronous, highest priority over accept and completion):
  - Clears out_valid_o and returns MUL/DIV to IDLE, abandoning the operation with HI/LO unchanged.
  - An op offered in the same cycle is not accepted.
- Reset mid-operation: same as flush, plus HI/LO are cleared.

Test Plan:
- Reset then ADD 0x7FFFFFFF+0x00000001 -> 0x80000000, overflow_o=1, negative_o=1, out_valid_o next cycle; ADDU same operands -> overflow_o=0.
- SUB 5-5 -> 0, zero_o=1. SRA 0x80000000 by 4 -> 0xF8000000. SLT -1,1 -> 1. SLTU -1,1 -> 0. LUI B=0x1234 -> 0x12340000.
- MULT 0xFFFFFFFE (-2) x 3: in_ready_o low for exactly 32 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFHI/MFLO return those values.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- Backpressure: out_ready_i=0 for 3 cycles after an ADD -> result/flags stable, in_ready_o=0; release -> next op accepted the same cycle.
- Assert pipeline_flush_i 10 cycles into MULTU after MTHI 0xA/MTLO 0xB -> no output beat, busy_o=0 next cycle, MFHI=0xA, MFLO=0xB.
